dm_stage_param: RTL and testbench
=================================

Name: dm_stage_param

Overview:
- Parametrised data-memory pipeline stage for the MIPS datapath, between EX and WB; successor of the fixed 16-bit single-cycle data memory stage.
- Adds configurable data/address width, byte-lane write enables and a programmable read latency.
- A stall/valid handshake toward the pipeline covers multi-cycle reads.
- Result mux selects either the memory read data or the forwarded ALU result (ans_ex) into a registered ans_dm.

Parameters:
- DATA_W, 16, data word width; must be a multiple of 8.
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- RD_LAT, 1, read latency in clock edges from issue to ans_dm update; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- DM_data  in  DATA_W  store data from EX.
- ans_ex  in  DATA_W  ALU result from EX; the address is ans_ex[ADDR_W-1:0] and upper bits are ignored.
- mem_rw_ex  in  1  1 = write, 0 = read.
- mem_en_ex  in  1  memory access enable.
- be_ex  in  DATA_W/8  byte-lane write enables; lane i covers bits [8i+7:8i].
- mem_mux_sel_dm  in  1  1 = result from memory, 0 = result is ans_ex.
- ans_dm  out  DATA_W  registered stage result.
- valid_dm  out  1  one-cycle pulse when ans_dm is updated with a new result.
- stall_dm  out  1  stage busy; upstream holds its inputs and they are ignored.

Behaviour:
- Reset (synchronous, takes effect at the edge where reset=1): ans_dm=0, valid_dm=0, stall_dm=0, state=IDLE, counter=0. Memory contents are preserved unless DM_CLEAR_EN is defined.
- FSM states: IDLE, RD_WAIT, CLR (CLR exists only with the macro).
- stall_dm = (state != IDLE), combinational from state.
- IDLE accepts one operation per edge:
  - Pass (mux_sel=0, or mem_en=0): ans_dm<=ans_ex, valid_dm<=1. If mem_en=1 and rw=1, the write also commits.
  - Write (mem_en=1, rw=1, mux_sel=1): enabled byte lanes written at the edge; ans_dm<=ans_ex; valid_dm<=1.
  - Read (mem_en=1, rw=0, mux_sel=1):
    - RD_LAT=1: ans_dm<=mem[addr], valid_dm<=1.
    - RD_LAT>1: latch addr, counter<=RD_LAT-1, state->RD_WAIT, valid_dm<=0.
  - Read with mux_sel=0: treated as Pass; no memory access.
- RD_WAIT:
  - counter decrements each edge.
  - On the edge where counter==1: ans_dm<=mem[latched addr], valid_dm<=1, state->IDLE.
  - stall_dm is high for exactly RD_LAT-1 cycles.
  - Inputs are ignored; no writes commit.
- be_ex=0 on a write: no lanes change, but ans_dm and valid_dm update as a normal write.
- Write followed by a read of the same address on the next cycle returns the new data. There is no same-cycle read/write.
- Reset asserted in RD_WAIT: the read is aborted, no valid pulse, state->IDLE (or CLR with the macro).
- Address wrap: addresses above 2**ADDR_W-1 alias via truncation.

Optional Feature:
- Macro DM_CLEAR_EN.
- Defined:
  - reset forces state=CLR and clr_ptr=0.
  - After reset deasserts, one word is zeroed per edge for addresses 0..2**ADDR_W-1.
  - stall_dm is high throughout CLR; state->IDLE after the last word is zeroed.
  - Reset during CLR restarts the clear at 0.
- Undefined: no CLR state, memory is never cleared, and stall_dm is low after reset.

Decomposition:
- Package dm_pkg holds:
  - the state enum (IDLE, RD_WAIT, CLR);
  - the lane-count constant DATA_W/8 helper;
  - the RD_LAT range check constants.
- One sub-module, dm_ram_be:
  - 2**ADDR_W x DATA_W array;
  - byte-enable synchronous write port;
  - combinational read port.
- The FSM, counter and result register live in dm_stage_param.

Test Plan:
- Pass-through: DATA_W=16, reset 1 cycle, then mux_sel=0, ans_ex=0x1234 -> next edge ans_dm=0x1234, valid_dm=1, stall_dm=0.
- Full write/read, RD_LAT=1: write DM_data=0xFFFF to addr 3 with be=2'b11, then read addr 3 -> one edge after the read ans_dm=0xFFFF, valid_dm=1.
- Byte lanes: addr 3 holds 0xFFFF; write 0xAB55 with be=2'b01, then read -> ans_dm=0xFF55; a write with be=2'b00 leaves 0xFF55 unchanged.
- Latency, RD_LAT=3: read addr 3 -> stall_dm high exactly 2 cycles; ans_dm=0xFF55 and valid_dm=1 on the 3rd edge; a write issued to addr 3 during the stall does not commit.
- Reset mid-read, RD_LAT=3: reset asserted on the 2nd cycle of RD_WAIT -> next edge ans_dm=0, valid_dm=0, stall_dm=0; a subsequent read of addr 3 still returns 0xFF55 (no macro).
- DM_CLEAR_EN, ADDR_W=8: after reset deasserts, stall_dm is high for exactly 256 cycles then drops; a read of addr 3 then returns 0x0000.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared types and constants for the dm_stage_param data-memory stage
package dm_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, CLR} dm_state_e;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;
  localparam int RD_LAT_CNT_W = $clog2(RD_LAT_MAX + 1);
  function automatic int lanes(input int w);
    return w / 8;
  endfunction
endpackage

// File: rtl/dm_ram_be.sv
// dm_ram_be: word array with byte-enable synchronous write and combinational read
module dm_ram_be import dm_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [lanes(DATA_W)-1:0]   be_i,
  input  logic [ADDR_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [ADDR_W-1:0]          raddr_i,
  output logic [DATA_W-1:0]          rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  // commit only the enabled byte lanes of the addressed word
  always_ff @(posedge clk)
    if (we_i)
      for (int i = 0; i < lanes(DATA_W); i++)
        if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dm_stage_param.sv
// dm_stage_param: MIPS EX->WB data-memory stage with byte lanes, RD_LAT read latency and optional post-reset clear (DM_CLEAR_EN)
module dm_stage_param import dm_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        DM_data,
  input  logic [DATA_W-1:0]        ans_ex,
  input  logic                     mem_rw_ex,
  input  logic                     mem_en_ex,
  input  logic [lanes(DATA_W)-1:0] be_ex,
  input  logic                     mem_mux_sel_dm,
  output logic [DATA_W-1:0]        ans_dm,
  output logic                     valid_dm,
  output logic                     stall_dm
);
  localparam int CNT_W = RD_LAT_CNT_W;
  dm_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic valid_q, valid_d;
  logic we;
  logic [lanes(DATA_W)-1:0] wbe;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] wdata, rdata;
`ifdef DM_CLEAR_EN
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
`endif

  dm_ram_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .we_i(we), .be_i(wbe), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata)
  );

  // state register, read counter and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DM_CLEAR_EN
      state_q <= CLR;
      clr_ptr_q <= '0;
`else
      state_q <= IDLE;
`endif
      cnt_q <= '0;
      addr_q <= '0;
      ans_q <= '0;
      valid_q <= 1'b0;
    end else begin
`ifdef DM_CLEAR_EN
      clr_ptr_q <= clr_ptr_d;
`endif
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      ans_q <= ans_d;
      valid_q <= valid_d;
    end
  end

  // next-state: accept one op in IDLE, count down a pending read, or walk the clear pointer
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    ans_d = ans_q;
    valid_d = 1'b0;
`ifdef DM_CLEAR_EN
    clr_ptr_d = clr_ptr_q;
`endif
    if (state_q == IDLE) begin
      if (mem_en_ex && !mem_rw_ex && mem_mux_sel_dm) begin
        if (RD_LAT == 1) begin
          ans_d = rdata;
          valid_d = 1'b1;
        end else begin
          addr_d = ans_ex[ADDR_W-1:0];
          cnt_d = CNT_W'(RD_LAT - 1);
          state_d = RD_WAIT;
        end
      end else begin
        ans_d = ans_ex;
        valid_d = 1'b1;
      end
    end else if (state_q == RD_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        ans_d = rdata;
        valid_d = 1'b1;
        state_d = IDLE;
      end
    end
`ifdef DM_CLEAR_EN
    else if (state_q == CLR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      state_d = clr_ptr_q == '1 ? IDLE : CLR;
    end
`endif
  end

  // outputs and memory port steering; writes only commit from IDLE (or the clear walk)
  always_comb begin
    stall_dm = state_q != IDLE;
    raddr = state_q == RD_WAIT ? addr_q : ans_ex[ADDR_W-1:0];
    we = !reset && state_q == IDLE && mem_en_ex && mem_rw_ex;
    waddr = ans_ex[ADDR_W-1:0];
    wdata = DM_data;
    wbe = be_ex;
`ifdef DM_CLEAR_EN
    if (state_q == CLR) begin
      we = !reset;
      waddr = clr_ptr_q;
      wdata = '0;
      wbe = '1;
    end
`endif
  end

  assign ans_dm = ans_q;
  assign valid_dm = valid_q;
endmodule

// File: tb/tb_dm_stage_param.sv
// tb_dm_stage_param: random and directed checks of dm_stage_param at RD_LAT=1 and RD_LAT=3 against a queue-free busy-count model
module tb_dm_stage_param;
  localparam int DW = 16, AW = 8, DEPTH = 2**AW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] DM_data = '0, ans_ex = '0;
  logic mem_rw_ex = 1'b0, mem_en_ex = 1'b0, mem_mux_sel_dm = 1'b0;
  logic [DW/8-1:0] be_ex = '0;
  logic [DW-1:0] ans1, ans3;
  logic valid1, valid3, stall1, stall3;
  int checks = 0, fails = 0;
  logic [DW-1:0] m [2][DEPTH];
  logic [DW-1:0] e_ans [2];
  logic e_val [2];
  int busy [2];
  bit rd [2];
  int paddr [2];
  int lat [2] = '{1, 3};
`ifdef DM_CLEAR_EN
  localparam int CLR_CYC = DEPTH;
`else
  localparam int CLR_CYC = 0;
`endif

  always #5 clk = ~clk;

  dm_stage_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .DM_data(DM_data), .ans_ex(ans_ex), .mem_rw_ex(mem_rw_ex),
    .mem_en_ex(mem_en_ex), .be_ex(be_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .ans_dm(ans1), .valid_dm(valid1), .stall_dm(stall1));
  dm_stage_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .DM_data(DM_data), .ans_ex(ans_ex), .mem_rw_ex(mem_rw_ex),
    .mem_en_ex(mem_en_ex), .be_ex(be_ex), .mem_mux_sel_dm(mem_mux_sel_dm),
    .ans_dm(ans3), .valid_dm(valid3), .stall_dm(stall3));

  task automatic drive(input logic en, input logic rw, input logic sel, input logic [1:0] be,
                       input logic [DW-1:0] data, input logic [DW-1:0] a);
    mem_en_ex = en; mem_rw_ex = rw; mem_mux_sel_dm = sel; be_ex = be; DM_data = data; ans_ex = a;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int a;
      a = int'(ans_ex) % DEPTH;
      e_val[k] = 1'b0;
      if (reset) begin
        e_ans[k] = '0;
        busy[k] = CLR_CYC;
        rd[k] = 1'b0;
        if (CLR_CYC > 0) for (int j = 0; j < DEPTH; j++) m[k][j] = '0;
      end else if (busy[k] > 0) begin
        busy[k]--;
        if (busy[k] == 0 && rd[k]) begin
          e_ans[k] = m[k][paddr[k]];
          e_val[k] = 1'b1;
          rd[k] = 1'b0;
        end
      end else if (mem_en_ex && !mem_rw_ex && mem_mux_sel_dm) begin
        if (lat[k] == 1) begin
          e_ans[k] = m[k][a];
          e_val[k] = 1'b1;
        end else begin
          paddr[k] = a;
          rd[k] = 1'b1;
          busy[k] = lat[k] - 1;
        end
      end else begin
        if (mem_en_ex && mem_rw_ex)
          for (int i = 0; i < DW/8; i++) if (be_ex[i]) m[k][a][8*i +: 8] = DM_data[8*i +: 8];
        e_ans[k] = ans_ex;
        e_val[k] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    drive(0, 0, 0, 2'b00, '0, '0);
    while ((stall1 || stall3) && n < 600) begin tick(); n++; end
    checks++;
    if (stall1 || stall3) begin fails++; $display("FAIL %s drain timeout: stall1=%b stall3=%b want 0 0", tag, stall1, stall3); end
  endtask

  task automatic test_reset();
    int n = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ans1 !== '0 || valid1 !== 1'b0 || stall1 !== (CLR_CYC > 0)) begin
      fails++; $display("FAIL reset dut1: ans=%h valid=%b stall=%b want 0000 0 %0d", ans1, valid1, stall1, CLR_CYC > 0);
    end
    checks++;
    if (ans3 !== '0 || valid3 !== 1'b0 || stall3 !== (CLR_CYC > 0)) begin
      fails++; $display("FAIL reset dut3: ans=%h valid=%b stall=%b want 0000 0 %0d", ans3, valid3, stall3, CLR_CYC > 0);
    end
    while (stall3 && n < 600) begin tick(); n++; end
    checks++;
    if (n !== CLR_CYC || stall1 !== 1'b0) begin
      fails++; $display("FAIL clear_len: stall cycles=%0d stall1=%b want %0d 0", n, stall1, CLR_CYC);
    end
  endtask

  task automatic test_init();
    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 1, 2'b11, DW'($urandom), DW'(a));
      tick();
    end
    drain("init");
  endtask

  task automatic test_pass();
    drive(0, 0, 0, 2'b00, 16'h0bad, 16'h1234);
    tick();
    checks++;
    if (ans1 !== 16'h1234 || valid1 !== 1'b1 || stall1 !== 1'b0) begin
      fails++; $display("FAIL pass dut1: ans=%h valid=%b stall=%b want 1234 1 0", ans1, valid1, stall1);
    end
    checks++;
    if (ans3 !== 16'h1234 || valid3 !== 1'b1 || stall3 !== 1'b0) begin
      fails++; $display("FAIL pass dut3: ans=%h valid=%b stall=%b want 1234 1 0", ans3, valid3, stall3);
    end
    drive(0, 1, 1, 2'b11, 16'h5555, 16'h0777);
    tick();
    checks++;
    if (ans1 !== 16'h0777 || valid3 !== 1'b1 || ans3 !== 16'h0777) begin
      fails++; $display("FAIL pass_en0: ans1=%h ans3=%h valid3=%b want 0777 0777 1", ans1, ans3, valid3);
    end
  endtask

  task automatic test_write_read();
    drive(1, 1, 1, 2'b11, 16'hFFFF, 16'h0003);
    tick();
    checks++;
    if (ans1 !== 16'h0003 || valid1 !== 1'b1 || stall3 !== 1'b0) begin
      fails++; $display("FAIL write_result: ans1=%h valid1=%b stall3=%b want 0003 1 0", ans1, valid1, stall3);
    end
    drive(1, 0, 1, 2'b00, '0, 16'h0003);
    tick();
    checks++;
    if (ans1 !== 16'hFFFF || valid1 !== 1'b1 || valid3 !== 1'b0 || stall3 !== 1'b1) begin
      fails++; $display("FAIL read_lat1: ans1=%h valid1=%b valid3=%b stall3=%b want ffff 1 0 1", ans1, valid1, valid3, stall3);
    end
    drive(0, 0, 0, 2'b00, '0, '0);
    tick();
    tick();
    checks++;
    if (ans3 !== 16'hFFFF || valid3 !== 1'b1 || stall3 !== 1'b0) begin
      fails++; $display("FAIL read_lat3: ans3=%h valid3=%b stall3=%b want ffff 1 0", ans3, valid3, stall3);
    end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] want [3] = '{16'hFF55, 16'hFF55, 16'hFF55};
    logic [1:0] bes [3] = '{2'b01, 2'b00, 2'b00};
    logic [DW-1:0] dat [3] = '{16'hAB55, 16'h1111, 16'h2222};
    for (int t = 0; t < 3; t++) begin
      drive(1, 1, t != 2, bes[t], dat[t], t == 2 ? 16'h0103 : 16'h0003);
      tick();
      drive(1, 0, 1, 2'b00, '0, 16'hA503);
      tick();
      checks++;
      if (ans1 !== want[t] || valid1 !== 1'b1) begin
        fails++; $display("FAIL lanes%0d dut1: ans=%h valid=%b want %h 1", t, ans1, valid1, want[t]);
      end
      drain("lanes");
      checks++;
      if (ans3 !== want[t]) begin
        fails++; $display("FAIL lanes%0d dut3: ans=%h want %h", t, ans3, want[t]);
      end
    end
  endtask

  task automatic test_latency();
    int n = 0;
    bit seen = 0;
    drive(1, 0, 1, 2'b00, '0, 16'h0003);
    tick();
    drive(1, 1, 1, 2'b11, 16'h0000, 16'h0003);
    while (stall3 && n < 20) begin
      checks++;
      if (valid3 !== 1'b0) begin fails++; $display("FAIL lat_valid_early: valid3=%b want 0", valid3); end
      tick();
      n++;
      drive(0, 0, 0, 2'b00, '0, '0);
      seen = valid3;
    end
    checks++;
    if (n !== 2 || !seen || ans3 !== 16'hFF55) begin
      fails++; $display("FAIL latency: stall cycles=%0d valid3=%b ans3=%h want 2 1 ff55", n, seen, ans3);
    end
    drive(1, 0, 1, 2'b00, '0, 16'h0003);
    tick();
    drain("lat");
    checks++;
    if (ans3 !== 16'hFF55 || ans3 !== e_ans[1] || ans1 !== e_ans[0]) begin
      fails++; $display("FAIL stall_write_blocked: ans3=%h ans1=%h want ff55 %h", ans3, ans1, e_ans[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 1, 2'b00, '0, 16'h0003);
    tick();
    drive(0, 0, 0, 2'b00, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ans3 !== '0 || valid3 !== 1'b0 || stall3 !== (CLR_CYC > 0)) begin
      fails++; $display("FAIL reset_mid_read: ans3=%h valid3=%b stall3=%b want 0000 0 %0d", ans3, valid3, stall3, CLR_CYC > 0);
    end
    drain("rst_mid");
    drive(1, 0, 1, 2'b00, '0, 16'h0003);
    tick();
    drain("rst_mid2");
    checks++;
    if (ans3 !== (CLR_CYC > 0 ? 16'h0000 : 16'hFF55)) begin
      fails++; $display("FAIL mem_after_reset: ans3=%h want %h", ans3, CLR_CYC > 0 ? 16'h0000 : 16'hFF55);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = $urandom_range(199) == 0;
      drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), DW'($urandom),
            {8'($urandom), 4'h0, 4'($urandom)});
      tick();
      checks++;
      if (ans1 !== e_ans[0] || valid1 !== e_val[0] || stall1 !== (busy[0] > 0)) begin
        fails++; $display("FAIL rand%0d dut1: ans=%h valid=%b stall=%b want %h %b %b", c, ans1, valid1, stall1, e_ans[0], e_val[0], busy[0] > 0);
      end
      checks++;
      if (ans3 !== e_ans[1] || valid3 !== e_val[1] || stall3 !== (busy[1] > 0)) begin
        fails++; $display("FAIL rand%0d dut3: ans=%h valid=%b stall=%b want %h %b %b", c, ans3, valid3, stall3, e_ans[1], e_val[1], busy[1] > 0);
      end
    end
    reset = 1'b0;
    drain("rand");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_pass();
    test_write_read();
    test_byte_lanes();
    test_latency();
    test_reset_mid_read();
    test_init();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
